// File: rtl/dimm_burst_engine.sv
// dimm_burst_engine: fixed-latency DIMM data-burst scheduler with bus-overlap and credit
// protection, critical-word-first read capture and a tagged valid/ready completion FIFO.
module dimm_burst_engine #(
  parameter int DATA_WIDTH    = 64,
  parameter int BURST_LEN     = 8,
  parameter int CAS_LATENCY   = 22,
  parameter int WRITE_LATENCY = 16,
  parameter int MAX_INFLIGHT  = 16,
  parameter int TAG_BITS      = 4
) (
  input  logic                               clk_in,
  input  logic                               rst_N_in,
  input  logic                               cmd_valid_in,
  output logic                               cmd_ready_out,
  input  logic                               cmd_write_in,
  input  logic [TAG_BITS-1:0]                cmd_tag_in,
  input  logic [$clog2(BURST_LEN)-1:0]       cmd_col_in,
  input  logic [BURST_LEN*DATA_WIDTH-1:0]    cmd_wdata_in,
  input  logic [DATA_WIDTH-1:0]              dq_in,
  output logic [DATA_WIDTH-1:0]              dq_out,
  output logic                               dq_oe_out,
  output logic                               resp_valid_out,
  input  logic                               resp_ready_in,
  output logic [TAG_BITS-1:0]                resp_tag_out,
  output logic                               resp_write_out,
  output logic [BURST_LEN*DATA_WIDTH-1:0]    resp_data_out,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight_out
);
  localparam int LW   = BURST_LEN * DATA_WIDTH;
  localparam int CB   = $clog2(BURST_LEN);
  localparam int PW   = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int CW   = $clog2(MAX_INFLIGHT + 1);
  localparam int LMAX = (CAS_LATENCY > WRITE_LATENCY) ? CAS_LATENCY : WRITE_LATENCY;
  localparam int KW   = $clog2(LMAX + 1);
  localparam int RW   = $clog2(LMAX + BURST_LEN);

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_INFLIGHT - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [TAG_BITS-1:0] r_s_tag  [MAX_INFLIGHT];
  logic                r_s_wr   [MAX_INFLIGHT];
  logic [CB-1:0]       r_s_col  [MAX_INFLIGHT];
  logic [LW-1:0]       r_s_data [MAX_INFLIGHT];
  logic [KW-1:0]       r_s_cnt  [MAX_INFLIGHT];
  logic [PW-1:0]       r_s_wp, r_s_rp;
  logic [CW-1:0]       r_s_n;
  logic [TAG_BITS-1:0] r_q_tag  [MAX_INFLIGHT];
  logic                r_q_wr   [MAX_INFLIGHT];
  logic [LW-1:0]       r_q_data [MAX_INFLIGHT];
  logic [PW-1:0]       r_q_wp, r_q_rp;
  logic [CW-1:0]       r_q_n;
  logic [CB-1:0]       r_beat;
  logic                r_act, r_oe, r_b_wr, r_b_last;
  logic [DATA_WIDTH-1:0] r_dq;
  logic [CB-1:0]       r_b_word;
  logic [TAG_BITS-1:0] r_b_tag;
  logic [LW-1:0]       r_line;
  logic [RW-1:0]       r_res;
  logic [CW-1:0]       r_inflight;

  logic [RW-1:0] w_lat;
  logic          w_acc, w_fire, w_spop, w_push, w_pop;
  logic [CB-1:0] w_word;
  logic [LW-1:0] w_line;

  assign w_lat         = cmd_write_in ? RW'(WRITE_LATENCY) : RW'(CAS_LATENCY);
  assign cmd_ready_out = rst_N_in && (r_inflight < CW'(MAX_INFLIGHT)) && (w_lat >= r_res);
  assign w_acc         = cmd_valid_in && cmd_ready_out;
  // Control runs one cycle ahead of the bus so beats leave/arrive through registers;
  // a head counter of 0 therefore means "next cycle is a beat" and entries start at L-2.
  assign w_fire        = (r_s_n != '0) && (r_s_cnt[r_s_rp] == '0);
  assign w_spop        = w_fire && (&r_beat);
  assign w_word        = r_s_col[r_s_rp] + r_beat;
  assign w_push        = r_act && r_b_last;
  assign w_pop         = resp_valid_out && resp_ready_in;

  always_comb begin
    w_line = r_line;
    w_line[r_b_word*DATA_WIDTH +: DATA_WIDTH] = dq_in;
  end

  assign dq_out         = r_dq;
  assign dq_oe_out      = r_oe;
  assign resp_valid_out = (r_q_n != '0);
  assign resp_tag_out   = resp_valid_out ? r_q_tag[r_q_rp] : '0;
  assign resp_write_out = resp_valid_out && r_q_wr[r_q_rp];
  assign resp_data_out  = resp_valid_out ? r_q_data[r_q_rp] : '0;
  assign inflight_out   = r_inflight;

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      r_s_wp     <= '0;
      r_s_rp     <= '0;
      r_s_n      <= '0;
      r_q_wp     <= '0;
      r_q_rp     <= '0;
      r_q_n      <= '0;
      r_beat     <= '0;
      r_act      <= 1'b0;
      r_oe       <= 1'b0;
      r_dq       <= '0;
      r_b_wr     <= 1'b0;
      r_b_word   <= '0;
      r_b_last   <= 1'b0;
      r_b_tag    <= '0;
      r_line     <= '0;
      r_res      <= '0;
      r_inflight <= '0;
    end else begin
      r_res      <= w_acc ? w_lat + RW'(BURST_LEN - 1) : ((r_res == '0) ? '0 : r_res - RW'(1));
      r_inflight <= r_inflight + CW'(w_acc) - CW'(w_pop);
      if (w_acc) r_s_wp <= inc(r_s_wp);
      if (w_spop) r_s_rp <= inc(r_s_rp);
      r_s_n      <= r_s_n + CW'(w_acc) - CW'(w_spop);
      if (w_fire) r_beat <= r_beat + CB'(1);
      r_act      <= w_fire;
      r_oe       <= w_fire && r_s_wr[r_s_rp];
      r_dq       <= (w_fire && r_s_wr[r_s_rp]) ? r_s_data[r_s_rp][w_word*DATA_WIDTH +: DATA_WIDTH] : '0;
      r_b_wr     <= r_s_wr[r_s_rp];
      r_b_word   <= w_word;
      r_b_last   <= &r_beat;
      r_b_tag    <= r_s_tag[r_s_rp];
      if (r_act && !r_b_wr) r_line <= w_line;
      if (w_push) r_q_wp <= inc(r_q_wp);
      if (w_pop) r_q_rp <= inc(r_q_rp);
      r_q_n      <= r_q_n + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < MAX_INFLIGHT; i++) r_s_cnt[i] <= (r_s_cnt[i] == '0) ? '0 : r_s_cnt[i] - KW'(1);
    if (w_acc) begin
      r_s_tag[r_s_wp]  <= cmd_tag_in;
      r_s_wr[r_s_wp]   <= cmd_write_in;
      r_s_col[r_s_wp]  <= cmd_col_in;
      r_s_data[r_s_wp] <= cmd_wdata_in;
      r_s_cnt[r_s_wp]  <= KW'(w_lat - RW'(2));
    end
    if (w_push) begin
      r_q_tag[r_q_wp]  <= r_b_tag;
      r_q_wr[r_q_wp]   <= r_b_wr;
      r_q_data[r_q_wp] <= r_b_wr ? '0 : w_line;
    end
  end
endmodule

// File: tb/tb_dimm_burst_engine.sv
// tb_dimm_burst_engine: directed and randomized checks of dimm_burst_engine against a
// cycle-level model built from absolute beat cycles, a bus-busy horizon and queues.
module tb_dimm_burst_engine;
  localparam int DW = 64, BL = 8, CL = 22, WL = 16, MI = 16, TB = 4, LW = DW * BL;

  logic            clk_in, rst_N_in, cmd_valid_in, cmd_ready_out, cmd_write_in;
  logic [TB-1:0]   cmd_tag_in, resp_tag_out;
  logic [2:0]      cmd_col_in;
  logic [LW-1:0]   cmd_wdata_in, resp_data_out;
  logic [DW-1:0]   dq_in, dq_out;
  logic            dq_oe_out, resp_valid_out, resp_ready_in, resp_write_out;
  logic [4:0]      inflight_out;

  dimm_burst_engine dut (
    .clk_in(clk_in), .rst_N_in(rst_N_in), .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_write_in(cmd_write_in), .cmd_tag_in(cmd_tag_in), .cmd_col_in(cmd_col_in),
    .cmd_wdata_in(cmd_wdata_in), .dq_in(dq_in), .dq_out(dq_out), .dq_oe_out(dq_oe_out),
    .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in), .resp_tag_out(resp_tag_out),
    .resp_write_out(resp_write_out), .resp_data_out(resp_data_out), .inflight_out(inflight_out)
  );

  int n_cmp = 0, n_err = 0, cyc = 0;
  bit dq_seq = 0;
  int rd_b0 = 0;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  always @(posedge clk_in) begin
    #1;
    dq_in = dq_seq ? 64'(100 + cyc - rd_b0) : {$urandom, $urandom};
  end

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Model: each accepted command owns bus cycles [start, start+BL) with start = accept+L;
  // a command may be taken only if its first beat lies beyond the last claimed bus cycle.
  typedef struct { int start; bit wr; logic [TB-1:0] tag; int col; logic [LW-1:0] line; } burst_t;
  typedef struct { logic [TB-1:0] tag; bit wr; logic [LW-1:0] data; } resp_t;
  burst_t bq[$];
  resp_t  rq[$];
  int m_infl = 0, last_busy = -1000;
  logic [LW-1:0] cap_line = '0;

  always @(negedge clk_in) begin : model
    int m0, k, w, lat;
    bit e_oe, e_rdy;
    logic [DW-1:0] e_dq;
    burst_t nb;
    resp_t nr;
    if (!rst_N_in) begin
      chk("rst_oe", dq_oe_out, 0);
      chk("rst_ready", cmd_ready_out, 0);
      chk("rst_resp_valid", resp_valid_out, 0);
      chk("rst_inflight", inflight_out, 0);
      bq.delete();
      rq.delete();
      m_infl = 0;
      last_busy = -1000;
    end else begin
      m0 = m_infl;
      chk("inflight", inflight_out, m0);
      chk("resp_valid", resp_valid_out, rq.size() != 0);
      if (rq.size() != 0) begin
        chk("resp_tag", resp_tag_out, rq[0].tag);
        chk("resp_write", resp_write_out, rq[0].wr);
        chk("resp_data", resp_data_out, rq[0].data);
        if (resp_ready_in) begin
          void'(rq.pop_front());
          m_infl--;
        end
      end
      e_oe = 0;
      e_dq = '0;
      if (bq.size() != 0 && bq[0].start <= cyc) begin
        k = cyc - bq[0].start;
        w = (bq[0].col + k) % BL;
        if (k == 0) cap_line = '0;
        if (bq[0].wr) begin
          e_oe = 1;
          e_dq = bq[0].line[w*DW +: DW];
        end else cap_line[w*DW +: DW] = dq_in;
        if (k == BL - 1) begin
          nr.tag = bq[0].tag;
          nr.wr = bq[0].wr;
          nr.data = bq[0].wr ? '0 : cap_line;
          rq.push_back(nr);
          void'(bq.pop_front());
        end
      end
      chk("dq_oe", dq_oe_out, e_oe);
      chk("dq_out", dq_out, e_dq);
      lat = cmd_write_in ? WL : CL;
      e_rdy = (m0 < MI) && (cyc + lat > last_busy);
      chk("cmd_ready", cmd_ready_out, e_rdy);
      if (cmd_valid_in && e_rdy) begin
        nb.start = cyc + lat;
        nb.wr = cmd_write_in;
        nb.tag = cmd_tag_in;
        nb.col = int'(cmd_col_in);
        nb.line = cmd_wdata_in;
        bq.push_back(nb);
        last_busy = cyc + lat + BL - 1;
        m_infl++;
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input bit wr, input logic [TB-1:0] tag, input logic [2:0] col,
                       input logic [LW-1:0] d, output int t);
    cmd_valid_in = 1;
    cmd_write_in = wr;
    cmd_tag_in = tag;
    cmd_col_in = col;
    cmd_wdata_in = d;
    t = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk_in);
      if (cmd_ready_out) begin
        t = cyc;
        break;
      end
      step();
    end
    if (t < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_timeout: tag %0d never accepted", tag);
    end
    step();
    cmd_valid_in = 0;
  endtask

  int f_oe, f_rv, s_rv, nw;
  logic [DW-1:0] wq[BL];
  logic [TB-1:0] rv_tag;
  logic rv_wr;
  logic [LW-1:0] rv_data;

  task automatic watch(input int ta, input int n);
    f_oe = -1; f_rv = -1; s_rv = -1; nw = 0;
    repeat (n) begin
      @(negedge clk_in);
      if (dq_oe_out) begin
        if (f_oe < 0) f_oe = cyc - ta;
        if (nw < BL) wq[nw] = dq_out;
        nw++;
      end
      if (resp_valid_out && resp_ready_in) begin
        if (f_rv < 0) begin
          f_rv = cyc - ta;
          rv_tag = resp_tag_out;
          rv_wr = resp_write_out;
          rv_data = resp_data_out;
        end else if (s_rv < 0) s_rv = cyc - ta;
      end
    end
    step();
  endtask

  initial begin
    int ta, tw, tb2, trel;
    bit acc, seen;
    logic [LW-1:0] d;
    rst_N_in = 0; cmd_valid_in = 0; cmd_write_in = 0; cmd_tag_in = '0; cmd_col_in = '0;
    cmd_wdata_in = '0; resp_ready_in = 1; dq_in = '0;
    repeat (3) @(posedge clk_in);
    #1;
    rst_N_in = 1;
    repeat (4) step();

    for (int i = 0; i < BL; i++) d[i*DW +: DW] = 64'(8'hA0 + i);
    issue(1, 4'h5, 3'd0, d, ta);
    watch(ta, 30);
    chk("wr_first_beat", f_oe, 16);
    chk("wr_beat_count", nw, 8);
    chk("wr_word0", wq[0], 64'hA0);
    chk("wr_word7", wq[7], 64'hA7);
    chk("wr_ack_cycle", f_rv, 24);
    chk("wr_ack_flag", rv_wr, 1);
    chk("wr_ack_data", rv_data, 0);

    issue(0, 4'h3, 3'd5, rand_line(), ta);
    rd_b0 = ta + CL;
    dq_seq = 1;
    watch(ta, 35);
    dq_seq = 0;
    chk("rd_resp_cycle", f_rv, 30);
    chk("rd_resp_tag", rv_tag, 3);
    chk("rd_word5", rv_data[5*DW +: DW], 100);
    chk("rd_word0", rv_data[0*DW +: DW], 103);
    chk("rd_word4", rv_data[4*DW +: DW], 107);

    issue(0, 4'h1, 3'd2, rand_line(), ta);
    issue(1, 4'h2, 3'd6, rand_line(), tw);
    chk("conflict_accept", tw - ta, 14);
    watch(tw, 20);
    chk("conflict_wr_beat", f_oe + tw - ta, 30);
    repeat (20) step();

    issue(0, 4'h6, 3'd2, rand_line(), ta);
    while (cyc < ta + 8) step();
    issue(0, 4'h7, 3'd3, rand_line(), tb2);
    chk("b2b_accept", tb2 - ta, 8);
    watch(ta, 40);
    chk("b2b_resp1", f_rv, 30);
    chk("b2b_resp2", s_rv, 38);

    resp_ready_in = 0;
    for (int i = 0; i < MI; i++) issue(0, 4'(i), 3'(i), rand_line(), ta);
    repeat (40) step();
    cmd_valid_in = 1; cmd_write_in = 0; cmd_tag_in = 4'h9;
    @(negedge clk_in);
    chk("full_inflight", inflight_out, 16);
    chk("full_ready", cmd_ready_out, 0);
    step();
    resp_ready_in = 1;
    @(negedge clk_in);
    chk("full_pop_tag", resp_tag_out, 0);
    chk("full_ready_popcyc", cmd_ready_out, 0);
    step();
    resp_ready_in = 0;
    @(negedge clk_in);
    chk("full_after_pop_inflight", inflight_out, 15);
    chk("full_after_pop_ready", cmd_ready_out, 1);
    step();
    cmd_valid_in = 0;
    resp_ready_in = 1;
    repeat (60) step();
    chk("full_drained", inflight_out, 0);

    issue(1, 4'hC, 3'd1, rand_line(), ta);
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk_in);
      seen = dq_oe_out;
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL rst_wait_oe: write beat never seen");
    end
    #1;
    rst_N_in = 0;
    #1;
    chk("rst_mid_oe", dq_oe_out, 0);
    chk("rst_mid_inflight", inflight_out, 0);
    chk("rst_mid_ready", cmd_ready_out, 0);
    step();
    step();
    rst_N_in = 1;
    trel = cyc;
    issue(0, 4'hD, 3'd0, rand_line(), ta);
    chk("rst_first_accept", ta - trel, 0);
    watch(ta, 35);
    chk("rst_only_resp_cycle", f_rv, 30);
    chk("rst_only_resp_tag", rv_tag, 4'hD);

    for (int c = 0; c < 3000; c++) begin
      if (!cmd_valid_in && $urandom_range(0, 2) == 0) begin
        cmd_write_in = 1'($urandom);
        cmd_tag_in = 4'($urandom);
        cmd_col_in = 3'($urandom);
        cmd_wdata_in = rand_line();
        cmd_valid_in = 1;
      end
      resp_ready_in = (c % 500 < 80) ? 1'b0 : ($urandom_range(0, 3) != 0);
      @(negedge clk_in);
      acc = cmd_valid_in && cmd_ready_out;
      step();
      if (acc) cmd_valid_in = 0;
    end
    cmd_valid_in = 0;
    resp_ready_in = 1;
    repeat (300) step();
    @(negedge clk_in);
    chk("final_inflight", inflight_out, 0);
    chk("final_resp_valid", resp_valid_out, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
